// File: rtl/program_loader.sv
// program_loader: UART boot loader that announces itself, receives a sized program and
// writes it little-endian into instruction memory before releasing the core.
module program_loader #(
  parameter int          IMEM_ADDR_W = 14,
  parameter logic [7:0]  HELLO_BYTE  = 8'h99,
  parameter logic [7:0]  DONE_BYTE   = 8'hAA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_rdata,
  input  logic                   rx_rdata_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_sdata,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   load_done,
  output logic                   load_error
);
  typedef enum logic [3:0] {
    SEND_HELLO, WAIT_HELLO_TX, RECV_SIZE, RECV_DATA, FLUSH,
    SEND_ACK, WAIT_ACK_TX, DONE, ERROR
  } state_t;

  localparam logic [32:0] CAP = 33'd4 << IMEM_ADDR_W;
  localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = {{(IMEM_ADDR_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [31:0]            size_q, size_d, cnt_q, cnt_d, asm_q, asm_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]             sidx_q, sidx_d;
  logic                   guard_q, guard_d;
  logic [7:0]             tx_sdata_q, tx_sdata_d;
  logic                   tx_start_q, tx_start_d, imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]            imem_wdata_q, imem_wdata_d;
  logic                   load_done_q, load_done_d, load_error_q, load_error_d;
  logic [31:0]            new_size, asm_next;
  logic                   lane3, last;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    addr_d       = addr_q;
    sidx_d       = sidx_q;
    guard_d      = guard_q;
    tx_sdata_d   = tx_sdata_q;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    new_size     = {rx_rdata, size_q[31:8]};
    asm_next     = asm_q;
    asm_next[{cnt_q[1:0], 3'b000} +: 8] = rx_rdata;
    lane3        = cnt_q[1:0] == 2'd3;
    last         = cnt_q + 32'd1 == size_q;
    case (state_q)
      SEND_HELLO, SEND_ACK: if (!tx_busy) begin
        tx_sdata_d = state_q == SEND_HELLO ? HELLO_BYTE : DONE_BYTE;
        tx_start_d = 1'b1;
        guard_d    = 1'b1;
        state_d    = state_q == SEND_HELLO ? WAIT_HELLO_TX : WAIT_ACK_TX;
      end
      // UART_TX raises busy a cycle late, so the first waiting cycle ignores it
      WAIT_HELLO_TX, WAIT_ACK_TX: begin
        guard_d = 1'b0;
        if (!guard_q && !tx_busy) begin
          state_d     = state_q == WAIT_HELLO_TX ? RECV_SIZE : DONE;
          sidx_d      = 2'd0;
          load_done_d = state_q == WAIT_ACK_TX;
        end
      end
      RECV_SIZE: if (rx_rdata_ready) begin
        if (rx_ferr) begin
          state_d      = ERROR;
          load_error_d = 1'b1;
        end else begin
          size_d = new_size;
          sidx_d = sidx_q + 2'd1;
          if (sidx_q == 2'd3) begin
            cnt_d  = 32'd0;
            addr_d = '0;
            asm_d  = 32'd0;
            if (new_size == 32'd0) state_d = SEND_ACK;
            else if ({1'b0, new_size} > CAP) begin
              state_d      = ERROR;
              load_error_d = 1'b1;
            end else state_d = RECV_DATA;
          end
        end
      end
      RECV_DATA: if (rx_rdata_ready) begin
        if (rx_ferr) begin
          state_d      = ERROR;
          load_error_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + 32'd1;
          asm_d        = lane3 ? 32'd0 : asm_next;
          imem_we_d    = lane3;
          imem_addr_d  = lane3 ? addr_q : imem_addr_q;
          imem_wdata_d = lane3 ? asm_next : imem_wdata_q;
          addr_d       = lane3 ? addr_q + ADDR_ONE : addr_q;
          if (last) state_d = lane3 ? SEND_ACK : FLUSH;
        end
      end
      FLUSH: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = addr_q;
        imem_wdata_d = asm_q;
        state_d      = SEND_ACK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEND_HELLO;
      size_q       <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      addr_q       <= '0;
      sidx_q       <= '0;
      guard_q      <= 1'b0;
      tx_sdata_q   <= '0;
      tx_start_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      addr_q       <= addr_d;
      sidx_q       <= sidx_d;
      guard_q      <= guard_d;
      tx_sdata_q   <= tx_sdata_d;
      tx_start_q   <= tx_start_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign tx_sdata   = tx_sdata_q;
  assign tx_start   = tx_start_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: host, UART_TX and memory models around program_loader with
// directed and random loads checked against a byte-list memory image.
module tb_program_loader;
  logic        clk = 0, reset = 0;
  logic [7:0]  rx_rdata = 0;
  logic        rx_rdata_ready = 0, rx_ferr = 0, tx_busy = 0;
  logic [7:0]  tx_sdata;
  logic        tx_start, imem_we, load_done, load_error;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;

  program_loader dut (
    .clk(clk), .reset(reset), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
    .rx_ferr(rx_ferr), .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, nwr = 0, wr_cyc = 0, tx_cyc = 0, last_cyc = 0, bcnt = 0;
  logic pend = 0;
  logic [7:0]  txq[$];
  logic [31:0] mem [0:63];

  // UART_TX model (busy from the cycle after tx_start for 5 cycles) and memory capture
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      tx_busy = 0; pend = 0; bcnt = 0;
    end else begin
      if (pend) begin tx_busy = 1; pend = 0; end
      else if (bcnt > 0) begin bcnt--; if (bcnt == 0) tx_busy = 0; end
      if (tx_start) begin txq.push_back(tx_sdata); tx_cyc = cyc; pend = 1; bcnt = 5; end
      if (imem_we) begin mem[imem_addr[5:0]] = imem_wdata; nwr++; wr_cyc = cyc; end
    end
  end

  initial begin #600000; $display("FAIL watchdog expired"); $fatal(1); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    @(posedge clk); #2;
    rx_rdata = b; rx_ferr = fe; rx_rdata_ready = 1; last_cyc = cyc;
    @(posedge clk); #2;
    rx_rdata_ready = 0; rx_ferr = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_size(input logic [31:0] s);
    for (int k = 0; k < 4; k++) send(s[8*k +: 8], 0);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (txq.size() == 0 && n < 300) begin @(posedge clk); n++; end
    chk(tag, txq.size() > 0 ? {24'd0, txq.pop_front()} : 32'hffffffff, {24'd0, exp});
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1; #1;
    chk("rst_tx_sdata", {24'd0, tx_sdata}, 0);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_imem_we", {31'd0, imem_we}, 0);
    chk("rst_imem_addr", {18'd0, imem_addr}, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_load_done", {31'd0, load_done}, 0);
    chk("rst_load_error", {31'd0, load_error}, 0);
    repeat (3) @(posedge clk);
    #3 reset = 0;
    txq.delete(); nwr = 0;
    for (int i = 0; i < 64; i++) mem[i] = 'x;
    wait_tx("hello", 8'h99);
    repeat (15) @(posedge clk);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] d[$], input int i);
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k++) if (4 * i + k < d.size()) w |= 32'(d[4 * i + k]) << (8 * k);
    return w;
  endfunction

  task automatic check_image(input string tag, input logic [7:0] d[$]);
    int n = 0;
    int words = (d.size() + 3) / 4;
    wait_tx({tag, "_ack"}, 8'hAA);
    while (!load_done && n < 50) begin @(posedge clk); n++; end
    #1;
    chk({tag, "_done"}, {31'd0, load_done}, 1);
    chk({tag, "_err"}, {31'd0, load_error}, 0);
    chk({tag, "_nwr"}, nwr, words);
    for (int i = 0; i < words; i++) chk($sformatf("%s_w%0d", tag, i), mem[i], word_of(d, i));
    if (words > 0) begin
      chk({tag, "_ack_after_wr"}, {31'd0, tx_cyc > wr_cyc}, 1);
      chk({tag, "_wr_lat"}, wr_cyc - last_cyc, d.size() % 4 == 0 ? 1 : 2);
    end
  endtask

  task automatic load(input string tag, input logic [7:0] d[$]);
    send_size(d.size());
    foreach (d[i]) send(d[i], 0);
    check_image(tag, d);
  endtask

  initial begin
    logic [7:0] d[$];
    reset = 1; #12 reset = 0;

    do_reset();
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
    load("size8", d);
    for (int i = 0; i < 4; i++) send(8'h5a, 0);
    repeat (30) @(posedge clk);
    chk("done_ignore_wr", nwr, 2);
    chk("done_ignore_tx", txq.size(), 0);

    do_reset();
    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load("size6", d);

    do_reset();
    d.delete();
    load("size0", d);

    do_reset();
    send_size(32'h00010001);
    repeat (3) @(posedge clk);
    chk("over_err", {31'd0, load_error}, 1);
    repeat (60) @(posedge clk);
    chk("over_nwr", nwr, 0);
    chk("over_noack", txq.size(), 0);
    chk("over_done", {31'd0, load_done}, 0);

    do_reset();
    send_size(8);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    for (int i = 0; i < 5; i++) send(8'h44, 0);
    repeat (40) @(posedge clk);
    chk("ferr_nwr", nwr, 0);
    chk("ferr_err", {31'd0, load_error}, 1);
    chk("ferr_noack", txq.size(), 0);
    chk("ferr_done", {31'd0, load_done}, 0);

    do_reset();
    send_size(8);
    for (int i = 0; i < 5; i++) send(8'hc0 + 8'(i), 0);
    do_reset();
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
    load("rerun", d);

    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, 40);
      do_reset();
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      load($sformatf("rand%0d", t), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

CPU-side boot loader between the CPU's UART_RX/UART_TX pair and instruction memory. After reset it announces itself to the host with 0x99, receives a 4-byte little-endian program byte count, then receives that many program bytes. It packs them little-endian into 32-bit words, writes them to instruction memory from word address 0, acknowledges with 0xAA, and holds `load_done` high to release the CPU core. Subsequent UART traffic (stdin, program output) belongs to the core, not to this block.

## Interface
- `IMEM_ADDR_W`, default 14: instruction-memory word-address width. Capacity is 4·2^IMEM_ADDR_W bytes.
- `HELLO_BYTE`, default 8'h99: byte sent to the host after reset.
- `DONE_BYTE`, default 8'hAA: byte sent to the host after the program is loaded.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_rdata` in 8: received byte from UART_RX.
- `rx_rdata_ready` in 1: one-cycle pulse; `rx_rdata` is valid in that cycle.
- `rx_ferr` in 1: framing error, qualified by `rx_rdata_ready`.
- `tx_sdata` out 8: byte to UART_TX.
- `tx_start` out 1: one-cycle transmit strobe.
- `tx_busy` in 1: UART_TX busy flag.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out IMEM_ADDR_W: word address.
- `imem_wdata` out 32: write word.
- `load_done` out 1: level; high once loading has completed.
- `load_error` out 1: level; high once an error has been detected.

## Operation
- States: SEND_HELLO, WAIT_HELLO_TX, RECV_SIZE, RECV_DATA, FLUSH, SEND_ACK, WAIT_ACK_TX, DONE, ERROR.
- SEND_HELLO: when `tx_busy`=0, drive `tx_sdata`=HELLO_BYTE, pulse `tx_start`, then go to WAIT_HELLO_TX.
- WAIT_HELLO_TX:
  - Ignore `tx_busy` for one guard cycle, because UART_TX raises busy one cycle late.
  - Then wait for `tx_busy`=0, and go to RECV_SIZE.
  - Bytes received before RECV_SIZE is entered are dropped.
- RECV_SIZE:
  - Shift in 4 bytes, LSB first, into a 32-bit `size`.
  - On the 4th byte:
    - size=0 → SEND_ACK.
    - size > 4·2^IMEM_ADDR_W → ERROR.
    - otherwise → RECV_DATA, with byte counter=0 and word address=0.
- RECV_DATA:
  - Each valid byte goes into lane (byte counter mod 4) of a 32-bit assembly register, lane 0 = bits 7:0.
  - When lane 3 is filled, write the word at the current address, increment the address, and clear the assembly register.
  - When byte counter+1 == size: if lane 3 was just filled → SEND_ACK; otherwise → FLUSH.
- FLUSH: write the partial word, with unfilled lanes zero, at the current address. Next state is SEND_ACK.
- SEND_ACK / WAIT_ACK_TX: same handshake as the hello, using DONE_BYTE. Then go to DONE.
- DONE: `load_done`=1 and stays high. All rx input is ignored, and no further tx or imem writes occur.
- ERROR:
  - Entered when `rx_rdata_ready`&`rx_ferr` in RECV_SIZE or RECV_DATA (the byte is discarded), or on an oversize length.
  - `load_error`=1 and stays high. No ack is sent, no further writes occur, and `load_done` stays 0.
- Only reset leaves DONE or ERROR.
- Arithmetic: byte counter and size are 32-bit unsigned; the address counter is IMEM_ADDR_W bits. The size check guarantees the address never wraps.

## Timing
- Reset values: `tx_sdata`=0, `tx_start`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `load_error`=0. State = SEND_HELLO.
- Reset asserted mid-load aborts immediately. Memory contents are not cleared.
- All outputs are registered.
- `tx_start` is high for exactly one cycle, and only in a cycle where the sampled `tx_busy`=0.
- `imem_we` is a one-cycle pulse, with `imem_addr`/`imem_wdata` valid in the same cycle.
  - A full word is written in the cycle after the `rx_rdata_ready` that carried its lane-3 byte.
  - The FLUSH write occurs 2 cycles after the last byte.
- The ack `tx_start` occurs no earlier than the cycle after the last imem write.
- `load_done` rises the cycle after `tx_busy` is first seen low following the ack guard cycle.
- Minimum byte spacing handled is 1 `rx_rdata_ready` every 2 cycles. Back-to-back UART bytes are ~10 bit-times apart, so there is no overrun.
- `rx_rdata_ready` arriving in the same cycle as a state transition is consumed by the new state only from the following cycle. The host never sends in those cycles.

## Test plan
- Size 8, bytes 13 00 00 00 | 93 00 00 00: host sees 0x99, then 0xAA.
  - Expected writes: addr0=0x00000013, addr1=0x00000093.
  - `load_done`=1 after the ack; `load_error`=0.
- Size 6, bytes 01..06: expect addr0=0x04030201, then a FLUSH write addr1=0x00000605, then 0xAA.
- Size 0: host sees 0x99 then 0xAA; no `imem_we` pulses; `load_done`=1.
- Size 0x00010001 with IMEM_ADDR_W=14: `load_error`=1 after the 4th size byte; no writes; no 0xAA.
- `rx_ferr` on the 3rd data byte of a size-8 load: exactly 0 writes; `load_error`=1; further bytes are ignored.
- Assert `reset` after 5 of 8 data bytes, then release and rerun the full size-8 sequence:
  - 0x99 is resent.
  - Address restarts at 0.
  - The final memory image is correct.
